// File: rtl/ex_unit_pkg.sv
// rtl/ex_unit_pkg.sv - shared opcodes, result classes, bus widths and divider state type
// No ports: imported by ex_unit_if, div_seq and ex_unit.
package ex_unit_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int DREG_BUS_W     = 64;
  localparam int ALU_OP_BUS_W   = 8;
  localparam int ALU_SEL_BUS_W  = 3;
  localparam int REG_ADDR_BUS_W = 5;

  localparam logic                 RstEnable = 1'b1;
  localparam logic [REG_BUS_W-1:0] ZeroWord  = 32'h0000_0000;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [7:0] EXE_CLZ_OP   = 8'b1011_0000;
  localparam logic [7:0] EXE_CLO_OP   = 8'b1011_0001;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
  localparam logic [2:0] EXE_RES_MUL        = 3'b101;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Leading-zero count, 0..32 (32 when v is all zeros).
  function automatic logic [5:0] count_lead_zeros(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/ex_unit_if.sv
// rtl/ex_unit_if.sv - execute-stage operand/result bundle
// master: decode/pipeline side (drives *_i, reads *_o); slave: ex_unit.
interface ex_unit_if;
  import ex_unit_pkg::*;

  logic [ALU_OP_BUS_W-1:0]   aluop_i;
  logic [ALU_SEL_BUS_W-1:0]  alusel_i;
  logic [REG_BUS_W-1:0]      reg1_i;
  logic [REG_BUS_W-1:0]      reg2_i;
  logic [REG_ADDR_BUS_W-1:0] wd_i;
  logic                      wreg_i;
  logic [REG_BUS_W-1:0]      hi_i;
  logic [REG_BUS_W-1:0]      lo_i;
  logic                      annul_i;

  logic [REG_ADDR_BUS_W-1:0] wd_o;
  logic                      wreg_o;
  logic [REG_BUS_W-1:0]      wdata_o;
  logic                      whilo_o;
  logic [REG_BUS_W-1:0]      hi_o;
  logic [REG_BUS_W-1:0]      lo_o;
  logic                      stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, annul_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, annul_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - radix-2 restoring divider, one quotient bit per cycle
// clk, rst      : clock, synchronous active-high reset
// start_i       : begin a divide (acted on only in IDLE)
// signed_i      : treat operands as two's complement
// opdata1_i/2_i : dividend / divisor
// annul_i       : abandon any divide, back to IDLE on next edge
// result_o      : {remainder, quotient}, sign-corrected
// ready_o       : result_o valid this cycle
module div_seq
  import ex_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [REG_BUS_W-1:0]  opdata1_i,
  input  logic [REG_BUS_W-1:0]  opdata2_i,
  input  logic                  annul_i,
  output logic [DREG_BUS_W-1:0] result_o,
  output logic                  ready_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;  // dividend shifts out the top as quotient bits shift in
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic        op1_neg, op2_neg;
  logic [31:0] op1_mag, op2_mag;
  logic [32:0] partial;

  always_comb begin
    op1_neg   = signed_i & opdata1_i[31];
    op2_neg   = signed_i & opdata2_i[31];
    op1_mag   = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_mag   = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;
    partial   = {rem_q, quo_q[31]};

    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      DIV_IDLE: begin
        if (start_i && !annul_i) begin
          dvs_d     = op2_mag;
          neg_rem_d = op1_neg;
          cnt_d     = 6'd0;
          if (opdata2_i == ZeroWord) begin
            // Quotient all ones, unsigned; remainder re-signs back to the dividend.
            quo_d     = 32'hFFFF_FFFF;
            rem_d     = op1_mag;
            neg_quo_d = 1'b0;
            state_d   = DIV_DONE;
          end else begin
            quo_d     = op1_mag;
            rem_d     = ZeroWord;
            neg_quo_d = op1_neg ^ op2_neg;
            state_d   = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          if (partial >= {1'b0, dvs_q}) begin
            rem_d = 32'(partial - {1'b0, dvs_q});
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = partial[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= 6'd0;
      quo_q     <= ZeroWord;
      dvs_q     <= ZeroWord;
      rem_q     <= ZeroWord;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign result_o = {(neg_rem_q ? (~rem_q + 32'd1) : rem_q),
                     (neg_quo_q ? (~quo_q + 32'd1) : quo_q)};
  assign ready_o  = (state_q == DIV_DONE) && !annul_i;

endmodule

// File: rtl/ex_unit.sv
// rtl/ex_unit.sv - execute stage: combinational ALU/MUL plus sequential divide
// clk, rst : clock, synchronous active-high reset
// ex       : ex_unit_if.slave (operands, HI/LO, annul in; write-back, HI/LO write, stall out)
module ex_unit
  import ex_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ex_unit_if.slave ex
);

  logic        valid_sel, div_op, div_ready, mult_signed;
  logic [63:0] div_result, mul_a, mul_b, product;
  logic [31:0] a, b, sum, diff;
  logic        add_ov, sub_ov;

  logic [4:0]  wd_c;
  logic        wreg_c, whilo_c, stall_c;
  logic [31:0] wdata_c, hi_c, lo_c;

  assign a         = ex.reg1_i;
  assign b         = ex.reg2_i;
  assign valid_sel = (ex.alusel_i <= EXE_RES_MUL);
  assign div_op    = valid_sel && ((ex.aluop_i == EXE_DIV_OP) || (ex.aluop_i == EXE_DIVU_OP));

  assign sum    = a + b;
  assign diff   = a - b;
  assign add_ov = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ov = (a[31] != b[31]) && (diff[31] != a[31]);

  // Sign- or zero-extend to 64 bits so one multiplier serves MUL, MULT and MULTU.
  assign mult_signed = (ex.aluop_i != EXE_MULTU_OP);
  assign mul_a       = {{32{mult_signed & a[31]}}, a};
  assign mul_b       = {{32{mult_signed & b[31]}}, b};
  assign product     = mul_a * mul_b;

  div_seq u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_op),
    .signed_i  (ex.aluop_i == EXE_DIV_OP),
    .opdata1_i (a),
    .opdata2_i (b),
    .annul_i   (ex.annul_i),
    .result_o  (div_result),
    .ready_o   (div_ready)
  );

  always_comb begin
    wd_c    = ex.wd_i;
    wreg_c  = ex.wreg_i;
    wdata_c = ZeroWord;
    whilo_c = 1'b0;
    hi_c    = ex.hi_i;
    lo_c    = ex.lo_i;
    stall_c = 1'b0;

    case (ex.alusel_i)
      EXE_RES_LOGIC: begin
        case (ex.aluop_i)
          EXE_AND_OP: wdata_c = a & b;
          EXE_OR_OP:  wdata_c = a | b;
          EXE_XOR_OP: wdata_c = a ^ b;
          EXE_NOR_OP: wdata_c = ~(a | b);
          default:    wdata_c = ZeroWord;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (ex.aluop_i)
          EXE_SLL_OP: wdata_c = b << a[4:0];
          EXE_SRL_OP: wdata_c = b >> a[4:0];
          EXE_SRA_OP: wdata_c = $unsigned($signed(b) >>> a[4:0]);
          default:    wdata_c = ZeroWord;
        endcase
      end
      EXE_RES_MOVE: begin
        case (ex.aluop_i)
          EXE_MFHI_OP:              wdata_c = ex.hi_i;
          EXE_MFLO_OP:              wdata_c = ex.lo_i;
          EXE_MOVZ_OP, EXE_MOVN_OP: wdata_c = a;
          default:                  wdata_c = ZeroWord;
        endcase
      end
      EXE_RES_ARITHMETIC: begin
        case (ex.aluop_i)
          EXE_ADD_OP, EXE_ADDI_OP: begin
            wdata_c = sum;
            if (add_ov) wreg_c = 1'b0;
          end
          EXE_ADDU_OP, EXE_ADDIU_OP: wdata_c = sum;
          EXE_SUB_OP: begin
            wdata_c = diff;
            if (sub_ov) wreg_c = 1'b0;
          end
          EXE_SUBU_OP: wdata_c = diff;
          EXE_SLT_OP:  wdata_c = {31'd0, $signed(a) < $signed(b)};
          EXE_SLTU_OP: wdata_c = {31'd0, a < b};
          EXE_CLZ_OP:  wdata_c = {26'd0, count_lead_zeros(a)};
          EXE_CLO_OP:  wdata_c = {26'd0, count_lead_zeros(~a)};
          default:     wdata_c = ZeroWord;
        endcase
      end
      EXE_RES_MUL: begin
        if (ex.aluop_i == EXE_MUL_OP) wdata_c = product[31:0];
      end
      default: wdata_c = ZeroWord;
    endcase

    // HI/LO writers are keyed on the opcode alone, within any known result class.
    if (valid_sel) begin
      case (ex.aluop_i)
        EXE_MTHI_OP: begin
          whilo_c = 1'b1;
          hi_c    = a;
        end
        EXE_MTLO_OP: begin
          whilo_c = 1'b1;
          lo_c    = a;
        end
        EXE_MULT_OP, EXE_MULTU_OP: begin
          whilo_c      = 1'b1;
          {hi_c, lo_c} = product;
          wreg_c       = 1'b0;
        end
        EXE_DIV_OP, EXE_DIVU_OP: begin
          wreg_c  = 1'b0;
          stall_c = !div_ready && !ex.annul_i;
          if (div_ready) begin
            whilo_c      = 1'b1;
            {hi_c, lo_c} = div_result;
          end
        end
        default: ;
      endcase
    end

    if (rst == RstEnable) begin
      wd_c    = 5'd0;
      wreg_c  = 1'b0;
      wdata_c = ZeroWord;
      whilo_c = 1'b0;
      hi_c    = ZeroWord;
      lo_c    = ZeroWord;
      stall_c = 1'b0;
    end
  end

  assign ex.wd_o       = wd_c;
  assign ex.wreg_o     = wreg_c;
  assign ex.wdata_o    = wdata_c;
  assign ex.whilo_o    = whilo_c;
  assign ex.hi_o       = hi_c;
  assign ex.lo_o       = lo_c;
  assign ex.stallreq_o = stall_c;

endmodule

// File: tb/tb_ex_unit.sv
// tb/tb_ex_unit.sv - scoreboard bench for ex_unit
module tb_ex_unit;
  import ex_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_unit_if bus();
  ex_unit dut (.clk(clk), .rst(rst), .ex(bus));

  localparam logic [31:0] HI_C = 32'h1234_5678;
  localparam logic [31:0] LO_C = 32'h9ABC_DEF0;

  typedef struct {
    string       name;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t base(input string name, input logic [4:0] wd, input logic wreg);
    exp_t e;
    e.name = name; e.wd = wd; e.wreg = wreg; e.wdata = 32'd0;
    e.whilo = 1'b0; e.hi = HI_C; e.lo = LO_C; e.stall = 1'b0;
    return e;
  endfunction

  function automatic exp_t zero_exp(input string name);
    exp_t e;
    e = base(name, 5'd0, 1'b0);
    e.hi = 32'd0; e.lo = 32'd0;
    return e;
  endfunction

  function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wd, input logic wreg);
    exp_t        e;
    longint      s;
    logic [63:0] pu;
    int          n;
    e = base($sformatf("op%02h", op), wd, wreg);
    case (op)
      EXE_AND_OP:  e.wdata = a & b;
      EXE_OR_OP:   e.wdata = a | b;
      EXE_XOR_OP:  e.wdata = a ^ b;
      EXE_NOR_OP:  e.wdata = ~a & ~b;
      EXE_SLL_OP:  e.wdata = b << a[4:0];
      EXE_SRL_OP:  e.wdata = b >> a[4:0];
      EXE_SRA_OP:  e.wdata = (b >> a[4:0]) | (b[31] ? ~(32'hFFFF_FFFF >> a[4:0]) : 32'd0);
      EXE_MFHI_OP: e.wdata = HI_C;
      EXE_MFLO_OP: e.wdata = LO_C;
      EXE_MOVZ_OP, EXE_MOVN_OP: e.wdata = a;
      EXE_MTHI_OP: begin e.whilo = 1'b1; e.hi = a; end
      EXE_MTLO_OP: begin e.whilo = 1'b1; e.lo = a; end
      EXE_ADD_OP, EXE_ADDI_OP, EXE_SUB_OP: begin
        if (op == EXE_SUB_OP) s = longint'($signed(a)) - longint'($signed(b));
        else                  s = longint'($signed(a)) + longint'($signed(b));
        e.wdata = s[31:0];
        if (s > 64'sd2147483647 || s < -64'sd2147483648) e.wreg = 1'b0;
      end
      EXE_ADDU_OP, EXE_ADDIU_OP: e.wdata = a + b;
      EXE_SUBU_OP: e.wdata = a + ~b + 32'd1;
      EXE_SLT_OP:  e.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      EXE_SLTU_OP: e.wdata = (a < b) ? 32'd1 : 32'd0;
      EXE_CLZ_OP, EXE_CLO_OP: begin
        n = 0;
        while (n < 32 && a[31-n] == (op == EXE_CLO_OP)) n++;
        e.wdata = 32'(n);
      end
      EXE_MUL_OP: begin
        s = longint'($signed(a)) * longint'($signed(b));
        e.wdata = s[31:0];
      end
      EXE_MULT_OP: begin
        s = longint'($signed(a)) * longint'($signed(b));
        e.whilo = 1'b1; e.wreg = 1'b0; e.hi = s[63:32]; e.lo = s[31:0];
      end
      EXE_MULTU_OP: begin
        pu = {32'd0, a} * {32'd0, b};
        e.whilo = 1'b1; e.wreg = 1'b0; e.hi = pu[63:32]; e.lo = pu[31:0];
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wreg, input logic annul);
    bus.aluop_i = op; bus.alusel_i = sel; bus.reg1_i = a; bus.reg2_i = b;
    bus.wd_i = wd; bus.wreg_i = wreg; bus.hi_i = HI_C; bus.lo_i = LO_C; bus.annul_i = annul;
  endtask

  // One cycle: compare outputs at the falling edge, then move just past the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.name, ".wd"},    64'(bus.wd_o),       64'(e.wd));
      chk({e.name, ".wreg"},  64'(bus.wreg_o),     64'(e.wreg));
      chk({e.name, ".wdata"}, 64'(bus.wdata_o),    64'(e.wdata));
      chk({e.name, ".whilo"}, 64'(bus.whilo_o),    64'(e.whilo));
      chk({e.name, ".hi"},    64'(bus.hi_o),       64'(e.hi));
      chk({e.name, ".lo"},    64'(bus.lo_o),       64'(e.lo));
      chk({e.name, ".stall"}, 64'(bus.stallreq_o), 64'(e.stall));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_step(input exp_t e);
    sb.push_back(e);
    step();
  endtask

  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                         input int stall_cycles);
    exp_t e;
    drive(op, EXE_RES_NOP, a, b, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < stall_cycles; i++) begin
      e = base({name, "_stall"}, 5'd9, 1'b0);
      e.stall = 1'b1;
      push_step(e);
    end
    e = base({name, "_done"}, 5'd9, 1'b0);
    e.whilo = 1'b1; e.hi = r; e.lo = q;
    push_step(e);
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [7:0] op_tab [26] = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP,
    EXE_SRL_OP, EXE_SRA_OP, EXE_MFHI_OP, EXE_MFLO_OP, EXE_MOVZ_OP, EXE_MOVN_OP, EXE_MTHI_OP,
    EXE_MTLO_OP, EXE_ADD_OP, EXE_ADDI_OP, EXE_ADDU_OP, EXE_ADDIU_OP, EXE_SUB_OP, EXE_SUBU_OP,
    EXE_SLT_OP, EXE_SLTU_OP, EXE_CLZ_OP, EXE_CLO_OP, EXE_MUL_OP, EXE_MULT_OP, EXE_MULTU_OP};
  logic [2:0] sel_tab [26] = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC,
    EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_MOVE,
    EXE_RES_MOVE, EXE_RES_NOP, EXE_RES_NOP, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC,
    EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC,
    EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC,
    EXE_RES_MUL, EXE_RES_NOP, EXE_RES_NOP};

  initial begin
    exp_t        e;
    logic [31:0] a, b, q, r;
    logic [4:0]  wd;
    logic        wr;
    longint      sq, sr;

    rst = 1'b1;
    drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFE, 32'd3, 5'd7, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    push_step(zero_exp("reset"));
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    drive(EXE_SUB_OP, EXE_RES_ARITHMETIC, 32'h8000_0000, 32'd1, 5'd3, 1'b1, 1'b0);
    e = base("sub_ovf", 5'd3, 1'b0); e.wdata = 32'h7FFF_FFFF; push_step(e);
    drive(EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'h8000_0000, 32'd1, 5'd3, 1'b1, 1'b0);
    e = base("subu", 5'd3, 1'b1); e.wdata = 32'h7FFF_FFFF; push_step(e);
    drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFE, 32'd3, 5'd4, 1'b1, 1'b0);
    e = base("mult_neg", 5'd4, 1'b0); e.whilo = 1'b1; e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFA;
    push_step(e);
    drive(EXE_CLZ_OP, EXE_RES_ARITHMETIC, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0);
    e = base("clz0", 5'd5, 1'b1); e.wdata = 32'd32; push_step(e);
    drive(EXE_CLO_OP, EXE_RES_ARITHMETIC, 32'hF000_0000, 32'd0, 5'd5, 1'b1, 1'b0);
    e = base("clo4", 5'd5, 1'b1); e.wdata = 32'd4; push_step(e);
    drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd31, 32'h8000_0000, 5'd6, 1'b1, 1'b0);
    e = base("sra31", 5'd6, 1'b1); e.wdata = 32'hFFFF_FFFF; push_step(e);
    drive(EXE_AND_OP, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1, 1'b0);
    push_step(base("bad_sel", 5'd8, 1'b1));
    drive(8'hEE, EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b0, 1'b0);
    push_step(base("bad_op", 5'd8, 1'b0));

    // Random single-cycle operations against the reference model.
    for (int i = 0; i < 260; i++) begin
      int k;
      k  = $urandom_range(0, 25);
      a  = pick();
      b  = pick();
      wd = 5'($urandom);
      wr = 1'($urandom);
      drive(op_tab[k], sel_tab[k], a, b, wd, wr, 1'b0);
      push_step(model(op_tab[k], a, b, wd, wr));
    end

    // Divides.
    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("divu_5_0", EXE_DIVU_OP, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
    run_div("div_m9_0", EXE_DIV_OP, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] op;
      op = i[0] ? EXE_DIV_OP : EXE_DIVU_OP;
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 28);
      if (b == 32'd0) b = 32'd1;
      if (op == EXE_DIV_OP) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        q  = sq[31:0];
        r  = sr[31:0];
      end else begin
        q = a / b;
        r = a % b;
      end
      run_div($sformatf("rdiv%0d", i), op, a, b, q, r, 33);
    end

    // Annul during BUSY iteration 10, then a clean divide.
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      e = base("annul_pre", 5'd9, 1'b0); e.stall = 1'b1; push_step(e);
    end
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd9, 1'b1, 1'b1);
    push_step(base("annul", 5'd9, 1'b0));
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd1, 1'b0, 1'b0);
    push_step(base("after_annul", 5'd1, 1'b0));
    run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    // Reset in the middle of a divide.
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd12345, 32'hFFFF_FFEF, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      e = base("rst_pre", 5'd9, 1'b0); e.stall = 1'b1; push_step(e);
    end
    rst = 1'b1;
    push_step(zero_exp("rst_mid"));
    rst = 1'b0;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd2, 1'b1, 1'b0);
    push_step(base("after_rst", 5'd2, 1'b1));
    run_div("divu_after_rst", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 clk  in  1  rising-edge clock for the divider state and all registered state.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 aluop_i  in  8  operation code from decode (EXE_*_OP set, plus EXE_DIV_OP and EXE_DIVU_OP).
REQ-004 alusel_i  in  3  result class: NOP, LOGIC, SHIFT, MOVE, ARITHMETIC or MUL.
REQ-005 reg1_i, reg2_i  in  32 each  operands; already forwarded, or carrying the immediate.
REQ-006 wd_i  in  5  destination register address.
REQ-007 wreg_i  in  1  destination write request.
REQ-008 hi_i, lo_i  in  32 each  current HI/LO, already forwarded.
REQ-009 annul_i  in  1  flush: abandon any divide in progress.
REQ-010 wd_o  out  5  destination register address.
REQ-011 wreg_o  out  1  register write enable.
REQ-012 wdata_o  out  32  register write data.
REQ-013 whilo_o  out  1  HI/LO write enable.
REQ-014 hi_o, lo_o  out  32 each  HI/LO write data.
REQ-015 stallreq_o  out  1  pipeline hold request.

Function
REQ-016 All non-divide results SHALL be combinational: zero latency, no stall.
- wd_o = wd_i.
- wreg_o = wreg_i, except the overflow cases in REQ-020.
REQ-017 LOGIC results:
- AND, OR, XOR: bitwise on reg1_i and reg2_i.
- NOR: ~(reg1_i | reg2_i).
REQ-018 SHIFT results:
- Data is reg2_i; shift amount is reg1_i[4:0].
- SLL logical left, SRL logical right, SRA arithmetic right.
REQ-019 MOVE results:
- MFHI returns hi_i; MFLO returns lo_i.
- MOVZ and MOVN return reg1_i.
- MTHI: whilo_o=1, hi_o=reg1_i, lo_o=lo_i.
- MTLO: whilo_o=1, lo_o=reg1_i, hi_o=hi_i.
REQ-020 ARITHMETIC results:
- ADD, ADDI, ADDU, ADDIU, SUB, SUBU: 32-bit wrap.
- ADD, ADDI, SUB: on signed overflow, wreg_o SHALL be 0.
- SLT compares signed; SLTU compares unsigned; result is 0 or 1.
- CLZ counts leading zeros of reg1_i; CLO counts leading ones; range 0..32.
REQ-021 MUL:
- Signed 32x32.
- wdata_o = product[31:0].
- HI/LO not written.
REQ-022 MULT and MULTU:
- MULT signed, MULTU unsigned.
- whilo_o=1, {hi_o,lo_o} = 64-bit product.
- wreg_o = 0.
REQ-023 Divider FSM states:
- IDLE: no divide active.
- BUSY: radix-2 restoring division, 6-bit counter.
- DONE: result presented.
REQ-024 IDLE with aluop_i DIV or DIVU and annul_i=0:
- Latch the operands (magnitudes for DIV).
- Latch the quotient and remainder signs.
- stallreq_o=1.
- reg2_i==0 goes directly to DONE; otherwise go to BUSY with counter=0.
REQ-025 BUSY:
- One quotient bit per cycle; stallreq_o=1.
- Leave for DONE after the 32nd iteration (counter==31).
REQ-026 DONE, held for one cycle, then IDLE:
- stallreq_o=0, whilo_o=1.
- lo_o = quotient, hi_o = remainder, sign-corrected for DIV.
- Quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
REQ-027 Normal divide timing:
- Accept cycle plus 32 BUSY cycles have stallreq_o=1.
- Result appears in cycle 33 after accept.
REQ-028 Divide by zero: lo_o=32'hFFFF_FFFF, hi_o=reg1_i, and the result appears in cycle 1 after accept.
REQ-029 Asserting annul_i in any state SHALL return the FSM to IDLE on the next edge.
- stallreq_o=0 and whilo_o=0 in that cycle.
- No HI/LO write occurs.
REQ-030 DIV and DIVU SHALL never assert wreg_o.
REQ-031 Unknown aluop_i or alusel_i SHALL yield:
- wdata_o=0, whilo_o=0, hi_o=hi_i, lo_o=lo_i.

Reset
REQ-032 With rst=1 at a clock edge:
- FSM goes to IDLE; counter, dividend/divisor, partial remainder and quotient registers, and sign flags clear to 0.
REQ-033 While rst=1, all outputs SHALL be 0, including stallreq_o, whilo_o and wreg_o.
REQ-034 Reset mid-divide SHALL discard the divide, with no HI/LO write.

Structure
REQ-035 The shared definitions file SHALL hold:
- all EXE_*_OP and EXE_RES_* codes, adding EXE_DIV_OP and EXE_DIVU_OP;
- bus-width macros;
- RstEnable, ZeroWord.
REQ-036 The iterative divider SHALL be a separate sub-module named div_seq.
- Ports: start, signed, opdata1, opdata2, annul, result[63:0], ready.
- ex_unit instantiates div_seq and owns stallreq_o.

Verification
REQ-037 SUB with reg1_i=32'h8000_0000, reg2_i=1 -> wreg_o=0; SUBU with the same operands -> wdata_o=32'h7FFF_FFFF, wreg_o=1.
REQ-038 MULT with reg1_i=-2, reg2_i=3 -> whilo_o=1, hi_o=32'hFFFF_FFFF, lo_o=32'hFFFF_FFFA.
REQ-039 DIV with reg1_i=-7, reg2_i=2, held through the stall -> stallreq_o high for 33 cycles, then one cycle with lo_o=-3, hi_o=-1, whilo_o=1.
REQ-040 DIVU with reg1_i=5, reg2_i=0 -> stall lasts 1 cycle, then lo_o=32'hFFFF_FFFF, hi_o=5.
REQ-041 annul_i pulsed at BUSY iteration 10 -> next cycle stallreq_o=0, whilo_o never asserted; a following DIVU 100/7 -> lo_o=14, hi_o=2.
REQ-042 CLZ with reg1_i=0 -> 32; CLO with reg1_i=32'hF000_0000 -> 4; SRA with reg2_i=32'h8000_0000, shift 31 -> 32'hFFFF_FFFF.
